fsm: RTL and testbench

Control FSM for the UART transmitter. It accepts a frame request on Data_Valid, then sequences the line through start bit, 8 data bits, optional parity bit and stop bit. It drives the serializer enable, the output-mux select and the busy flag. It advances between frame segments on the ser_done strobe from the serializer/bit-timer.

---
 rtl/uart_tx_pkg.sv | 24 ++
 rtl/fsm.sv | 97 +++++++++
 tb/tb_fsm.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared constants for the UART transmitter: control FSM state encoding and
// TX output-mux select codes (the mux codes are also used by the TX line mux).
// No ports.
// -----------------------------------------------------------------------------
package uart_tx_pkg;

   // Frame segment states. Encodings 5..7 are unused and recover to IDLE.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

   // TX line source select
   localparam logic [1:0] MUX_START = 2'b00;  // constant 0
   localparam logic [1:0] MUX_STOP  = 2'b01;  // constant 1 (stop / idle line)
   localparam logic [1:0] MUX_DATA  = 2'b10;  // serializer output
   localparam logic [1:0] MUX_PAR   = 2'b11;  // parity bit

endpackage

// File: rtl/fsm.sv
// -----------------------------------------------------------------------------
// fsm
// UART transmitter control FSM. Accepts a frame request, then steps the line
// through start, 8 data bits, optional parity and stop, advancing one segment
// per ser_done strobe. Outputs are Moore, decoded from the state register.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   Data_Valid in   frame request (sampled in IDLE and on STOP exit)
//   PAR_EN     in   parity enable, latched when a frame is accepted
//   ser_done   in   one-cycle strobe: current segment complete
//   ser_en     out  serializer shift enable (DATA only)
//   busy       out  frame in progress
//   mux_sel    out  TX line source select (see uart_tx_pkg)
// -----------------------------------------------------------------------------
module fsm
   import uart_tx_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       Data_Valid,
   input  logic       PAR_EN,
   input  logic       ser_done,
   output logic       ser_en,
   output logic       busy,
   output logic [1:0] mux_sel
);

   state_e state_q, state_d;
   logic   par_en_q, par_en_d;

   always_comb begin
      state_d  = state_q;
      par_en_d = par_en_q;
      unique case (state_q)
         IDLE: begin
            if (Data_Valid) begin
               state_d  = START;
               par_en_d = PAR_EN;
            end
         end
         START: begin
            if (ser_done) state_d = DATA;
         end
         DATA: begin
            if (ser_done) state_d = par_en_q ? PARITY : STOP;
         end
         PARITY: begin
            if (ser_done) state_d = STOP;
         end
         STOP: begin
            // Back-to-back frame: skip IDLE when the next request is waiting.
            if (ser_done) begin
               if (Data_Valid) begin
                  state_d  = START;
                  par_en_d = PAR_EN;
               end else begin
                  state_d  = IDLE;
               end
            end
         end
         default: state_d = IDLE;  // unused encodings recover
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         par_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         par_en_q <= par_en_d;
      end
   end

   // Moore output decode; unused encodings look like IDLE on the line.
   always_comb begin
      ser_en  = 1'b0;
      busy    = 1'b1;
      mux_sel = MUX_STOP;
      unique case (state_q)
         START:  mux_sel = MUX_START;
         DATA: begin
            ser_en  = 1'b1;
            mux_sel = MUX_DATA;
         end
         PARITY: mux_sel = MUX_PAR;
         STOP:   mux_sel = MUX_STOP;
         default: begin
            busy    = 1'b0;
            mux_sel = MUX_STOP;
         end
      endcase
   end

endmodule

// File: tb/tb_fsm.sv
// -----------------------------------------------------------------------------
// tb_fsm
// Bench for the UART TX control FSM. The reference keeps the remaining
// segments of the current frame in a queue; the head is the segment on the
// line, an empty queue means the line is idle.
// -----------------------------------------------------------------------------
module tb_fsm;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       Data_Valid = 1'b0;
   logic       PAR_EN = 1'b0;
   logic       ser_done = 1'b0;
   logic       ser_en;
   logic       busy;
   logic [1:0] mux_sel;

   int vectors = 0;
   int miscompares = 0;

   localparam int SEG_START = 0;
   localparam int SEG_DATA  = 1;
   localparam int SEG_PAR   = 2;
   localparam int SEG_STOP  = 3;

   int segq[$];

   fsm dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .ser_done   (ser_done),
      .ser_en     (ser_en),
      .busy       (busy),
      .mux_sel    (mux_sel)
   );

   always #5 clk = ~clk;

   // Reference: a frame is a list of segments consumed one per ser_done.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         segq.delete();
      end else if (segq.size() == 0) begin
         if (Data_Valid) begin
            segq.push_back(SEG_START);
            segq.push_back(SEG_DATA);
            if (PAR_EN) segq.push_back(SEG_PAR);
            segq.push_back(SEG_STOP);
         end
      end else if (ser_done) begin
         if (segq[0] == SEG_STOP && Data_Valid) begin
            segq.delete();
            segq.push_back(SEG_START);
            segq.push_back(SEG_DATA);
            if (PAR_EN) segq.push_back(SEG_PAR);
            segq.push_back(SEG_STOP);
         end else begin
            void'(segq.pop_front());
         end
      end
   end

   // Per-cycle compare against the reference, away from the active edge.
   always @(negedge clk) begin
      logic       e_en, e_busy;
      logic [1:0] e_mux;
      e_en   = 1'b0;
      e_busy = (segq.size() != 0);
      e_mux  = 2'b01;
      if (segq.size() != 0) begin
         case (segq[0])
            SEG_START: e_mux = 2'b00;
            SEG_DATA:  begin e_mux = 2'b10; e_en = 1'b1; end
            SEG_PAR:   e_mux = 2'b11;
            default:   e_mux = 2'b01;
         endcase
      end
      vectors++;
      if (ser_en !== e_en || busy !== e_busy || mux_sel !== e_mux) begin
         miscompares++;
         $display("FAIL model t=%0t got en=%b busy=%b mux=%b want en=%b busy=%b mux=%b",
                  $time, ser_en, busy, mux_sel, e_en, e_busy, e_mux);
      end
   end

   // Hand-computed literal expectations
   task automatic expect_lit(input string name, input logic en, input logic bz,
                             input logic [1:0] mx);
      vectors++;
      if (ser_en !== en || busy !== bz || mux_sel !== mx) begin
         miscompares++;
         $display("FAIL %s got en=%b busy=%b mux=%b want en=%b busy=%b mux=%b",
                  name, ser_en, busy, mux_sel, en, bz, mx);
      end
   endtask

   // Apply inputs for one cycle; returns at the following negedge.
   task automatic step(input logic dv, input logic pe, input logic sd);
      Data_Valid = dv;
      PAR_EN     = pe;
      ser_done   = sd;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      // Reset held with active inputs
      Data_Valid = 1'b1;
      ser_done   = 1'b1;
      #1 expect_lit("rst_imm", 1'b0, 1'b0, 2'b01);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         expect_lit("rst_hold", 1'b0, 1'b0, 2'b01);
      end
      rst_n = 1'b1;
      step(0, 0, 0); expect_lit("post_rst", 1'b0, 1'b0, 2'b01);
      step(0, 0, 1); expect_lit("idle_sd_ignored", 1'b0, 1'b0, 2'b01);

      // No-parity frame
      step(1, 0, 0); expect_lit("np_start", 1'b0, 1'b1, 2'b00);
      step(0, 0, 1); expect_lit("np_data", 1'b1, 1'b1, 2'b10);
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 0); expect_lit("np_data_hold", 1'b1, 1'b1, 2'b10);
      end
      step(0, 0, 1); expect_lit("np_stop", 1'b0, 1'b1, 2'b01);
      step(0, 0, 1); expect_lit("np_idle", 1'b0, 1'b0, 2'b01);

      // Parity frame, PAR_EN dropped during DATA
      step(1, 1, 0); expect_lit("p_start", 1'b0, 1'b1, 2'b00);
      step(0, 1, 1); expect_lit("p_data", 1'b1, 1'b1, 2'b10);
      step(0, 0, 0); expect_lit("p_data_pe0", 1'b1, 1'b1, 2'b10);
      step(0, 0, 1); expect_lit("p_parity", 1'b0, 1'b1, 2'b11);
      step(0, 0, 1); expect_lit("p_stop", 1'b0, 1'b1, 2'b01);
      step(0, 0, 1); expect_lit("p_idle", 1'b0, 1'b0, 2'b01);

      // No parity requested, PAR_EN raised during DATA: PARITY skipped
      step(1, 0, 0); expect_lit("c_start", 1'b0, 1'b1, 2'b00);
      step(1, 1, 0); expect_lit("c_start_dv_ign", 1'b0, 1'b1, 2'b00);
      step(0, 1, 1); expect_lit("c_data", 1'b1, 1'b1, 2'b10);
      step(1, 1, 0); expect_lit("c_data_dv_ign", 1'b1, 1'b1, 2'b10);
      step(0, 1, 1); expect_lit("c_stop_skip_par", 1'b0, 1'b1, 2'b01);
      // Back-to-back: request coincident with ser_done in STOP, now with parity
      step(1, 1, 1); expect_lit("b2b_start", 1'b0, 1'b1, 2'b00);
      step(0, 0, 1); expect_lit("b2b_data", 1'b1, 1'b1, 2'b10);
      step(0, 0, 1); expect_lit("b2b_parity", 1'b0, 1'b1, 2'b11);
      step(0, 0, 1); expect_lit("b2b_stop", 1'b0, 1'b1, 2'b01);
      step(0, 0, 0); expect_lit("b2b_stop_hold", 1'b0, 1'b1, 2'b01);
      step(0, 0, 1); expect_lit("b2b_idle", 1'b0, 1'b0, 2'b01);

      // Async reset mid-DATA, between clock edges
      step(1, 1, 0);
      step(0, 0, 1); expect_lit("ar_data", 1'b1, 1'b1, 2'b10);
      Data_Valid = 1'b0; ser_done = 1'b0;
      #2 rst_n = 1'b0;
      #1 expect_lit("ar_immediate", 1'b0, 1'b0, 2'b01);
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 0); expect_lit("ar_after", 1'b0, 1'b0, 2'b01);

      // Randomized traffic against the reference
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
         step(($urandom_range(0, 3) == 0), $urandom_range(0, 1),
              ($urandom_range(0, 9) < 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
